lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
- Load/store unit for the RISC-V core: the initiator side of the data-memory interface.
- Accepts one load or store at a time from the execute/memory stage and drives the word-wide data memory (addr/wdata/wmem/rmem/memsz, combinational rdata).
- Handles byte and halfword access: lane extraction and sign/zero extension on loads, read-modify-write on sub-word stores (the memory has no byte enables).
- Returns a single-cycle response pulse to the pipeline.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the data memory; word index addr[31:2] >= MEM_WORDS is out of range.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle and accepting a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  zero-extend loads (LBU/LHU)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  access faulted; valid with resp_valid
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  output  32  full word to write
- mem_wmem  output  1  write strobe
- mem_rmem  output  1  read strobe
- mem_memsz  output  2  request size on loads, 2'b10 on every write
- mem_rdata  input  32  memory read data, combinational from mem_addr

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; all mem_* outputs=0.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- req_ready=1 only in IDLE and not rst. Handshake fires on req_valid&&req_ready. The request (we, size, unsigned, addr, wdata) is latched on the handshake.
- IDLE on handshake:
  - error -> RESP with err=1;
  - load -> LOAD;
  - word store -> WRITE, merge register = wdata;
  - byte/half store -> RMW_RD.
- Error conditions:
  - size=11;
  - word index >= MEM_WORDS;
  - misalignment, only with the optional feature below.
- LOAD: mem_rmem=1, mem_addr driven. Capture mem_rdata.
  - Byte: select lane addr[1:0], sign-extend bit 7 unless unsigned.
  - Half: select lane addr[1], sign-extend bit 15 unless unsigned.
  - Word: as read.
  - Write the result into resp_rdata, then -> RESP.
- RMW_RD: mem_rmem=1. Capture mem_rdata into the merge register, replacing byte lane addr[1:0] with wdata[7:0] (byte) or half lane addr[1] with wdata[15:0] (half). Other lanes unchanged. -> WRITE.
- WRITE: mem_wmem=1, mem_wdata=merge register, mem_memsz=10. -> RESP.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata and resp_err held from capture (0 for stores). -> IDLE.
- There is no response backpressure; the pipeline stalls on !req_ready and must consume the pulse.
- mem_* outputs are 0 in IDLE and RESP. mem_addr is valid in LOAD, RMW_RD and WRITE.
- Latency, with the handshake at cycle T:
  - word store: write at T+1, resp at T+2;
  - load: read at T+1, resp at T+2;
  - sub-word store: read at T+1, write at T+2, resp at T+3;
  - error: resp at T+1, no memory strobe ever asserted.
- req_valid while not ready is ignored. Request inputs may change freely outside the handshake cycle.
- Back-to-back: a new handshake is possible the cycle after RESP (IDLE).
- Reset mid-operation: mem_wmem and mem_rmem are gated by !rst, so no write occurs in the rst cycle. Next state is IDLE; any pending response is dropped (no resp_valid).

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: a half with addr[0]!=0, or a word with addr[1:0]!=00, is an error (resp_err=1 at T+1, no memory access).
- Undefined: low address bits that would be misaligned are ignored:
  - half uses lane addr[1];
  - word uses addr[31:2].
  - resp_err is raised only for size=11 or out-of-range.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word 0x10 -> exactly one mem_wmem cycle at T+1, resp at T+2; load resp_rdata=0xDEADBEEF.
- Preload 0x11223344 at 0x20; store byte 0xAA at 0x21 -> one read cycle then a write of 0x1122AA44; resp at T+3; resp_err=0.
- Word 0x8000F0FF at 0x30: LB 0x30 -> 0xFFFFFFFF; LBU 0x30 -> 0x000000FF; LH 0x32 -> 0xFFFF8000; LHU 0x32 -> 0x00008000.
- Load at 0x00001000 (word 1024, MEM_WORDS=1024), and any request with size=11 -> resp_err=1 at T+1, resp_rdata=0, no mem_rmem/mem_wmem.
- LSU_ALIGN_CHECK_EN defined: LW at 0x22 -> resp_err=1 and no access. Undefined: LW at 0x22 returns the word at 0x20.
- Assert rst during the WRITE cycle of a sub-word store -> mem_wmem=0 in that cycle, the memory word is unchanged, no resp_valid, and req_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : Load/store unit, initiator side of the word-wide data memory.
//               One request at a time; byte/half loads are lane-extracted and
//               sign/zero extended, byte/half stores use read-modify-write.
//               Optional macro LSU_ALIGN_CHECK_EN turns misaligned half/word
//               accesses into errors instead of ignoring the low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wmem,
    output logic        mem_rmem,
    output logic [1:0]  mem_memsz,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_merge;    // store data, becomes the full word to write
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_fire;
    logic        w_misalign;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_fire = req_valid && (r_state == S_IDLE) && !rst;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (req_size == 2'b11) || (req_addr[31:2] >= c_mem_words) || w_misalign;

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and memory/handshake outputs; everything is quiet during rst
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_wmem   = 1'b0;
        mem_rmem   = 1'b0;
        mem_memsz  = 2'b00;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (w_err) begin
                            w_next = S_RESP;
                        end else if (!req_we) begin
                            w_next = S_LOAD;
                        end else if (req_size == 2'b10) begin
                            w_next = S_WRITE;
                        end else begin
                            w_next = S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    mem_addr  = {r_addr[31:2], 2'b00};
                    mem_rmem  = 1'b1;
                    mem_memsz = r_size;
                    w_next    = S_RESP;
                end
                S_RMW_RD: begin
                    mem_addr  = {r_addr[31:2], 2'b00};
                    mem_rmem  = 1'b1;
                    mem_memsz = 2'b10;
                    w_next    = S_WRITE;
                end
                S_WRITE: begin
                    mem_addr  = {r_addr[31:2], 2'b00};
                    mem_wdata = r_merge;
                    mem_wmem  = 1'b1;
                    mem_memsz = 2'b10;
                    w_next    = S_RESP;
                end
                S_RESP: begin
                    resp_valid = 1'b1;
                    w_next     = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Lane extraction and extension of the word read in LOAD
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{w_byte[7] & ~r_uns}}, w_byte};
            2'b01:   w_load_data = {{16{w_half[15] & ~r_uns}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Merge of the store data into the word read in RMW_RD
    always_comb begin
        w_merged = mem_rdata;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_merge[7:0];
                2'd1:    w_merged[15:8]  = r_merge[7:0];
                2'd2:    w_merged[23:16] = r_merge[7:0];
                default: w_merged[31:24] = r_merge[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_merge[15:0];
        end else begin
            w_merged[15:0] = r_merge[15:0];
        end
    end

    // Request latch, load capture and RMW merge register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= 32'h0;
            r_merge <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_fire) begin
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_merge <= req_wdata;
            r_rdata <= 32'h0;
            r_err   <= w_err;
        end else if (r_state == S_LOAD) begin
            r_rdata <= w_load_data;
        end else if (r_state == S_RMW_RD) begin
            r_merge <= w_merged;
        end
    end

endmodule
`default_nettype wire
